// File: rtl/i2c_arb_pkg.sv
// Shared types and sizing helpers for the I2C transmitter arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1
    } state_t;

    localparam int unsigned DEF_NUM_REQ         = 4;
    localparam int unsigned DEF_I2C_DATA_WIDTH  = 8;
    localparam int unsigned DEF_AXIS_DATA_WIDTH = DEF_I2C_DATA_WIDTH * 2;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned gnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned GNT_W = gnt_w(DEF_NUM_REQ);

    typedef logic [DEF_AXIS_DATA_WIDTH-1:0] axis_word_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake plus data.
interface axis_if #(
    parameter int unsigned DW = 16
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so the search
// starts just above the previous grant, then take the lowest set bit.
module rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned GW = gnt_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_gnt,
    output logic [GW-1:0] winner,
    output logic          any_req
);

    logic [N-1:0] rot;
    int unsigned  start;
    int unsigned  off;
    int unsigned  sum;
    logic         found;

    // Double-width rotate followed by a lowest-set-bit priority encoder.
    always_comb begin
        start   = (32'(last_gnt) + 32'd1) % N;
        rot     = N'({req, req} >> start);
        off     = 0;
        found   = 1'b0;
        any_req = |req;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                off   = i;
                found = 1'b1;
            end
        end
        sum = start + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = GW'(sum);
    end

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter sharing one AXIS-fed I2C transmitter between requesters.
module axis_i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ         = DEF_NUM_REQ,
    parameter  int unsigned I2C_DATA_WIDTH  = DEF_I2C_DATA_WIDTH,
    parameter  int unsigned AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter  int unsigned TIMEOUT         = 256,
    localparam int unsigned GW              = gnt_w(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   s_tvalid,
    input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]   s_tdata,
    output logic [NUM_REQ-1:0]                   s_tready,
    input  logic [NUM_REQ-1:0]                   req_en,
    axis_if.master                               m_axis,
    output logic [GW-1:0]                        gnt_id,
    output logic                                 busy,
    output logic                                 timeout_err,
    output logic [GW-1:0]                        err_id
);

    localparam int unsigned CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   winner;
    logic            any_req;
    logic            hs;
    logic            to_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req      (s_tvalid & req_en),
        .last_gnt (gnt_id),
        .winner   (winner),
        .any_req  (any_req)
    );

    // Handshake / timeout detection for the word currently held on m_axis.
    always_comb begin
        hs     = (state == SEND) && m_axis.tready;
        to_hit = (TIMEOUT != 0) && (state == SEND) && (cnt == CW'(TO_LAST)) && !m_axis.tready;
    end

    // Upstream ready mirrors downstream ready for the granted port; a timeout
    // forces it so the stale word is consumed and dropped.
    always_comb begin
        s_tready = '0;
        if (hs || to_hit) begin
            s_tready[gnt_id] = 1'b1;
        end
    end

    // Arbitration FSM with registered master-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            err_id        <= '0;
            cnt           <= '0;
            gnt_id        <= GW'(NUM_REQ - 1);
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ARB: begin
                    if (any_req) begin
                        gnt_id        <= winner;
                        m_axis.tdata  <= s_tdata[32'(winner)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                        m_axis.tvalid <= 1'b1;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        state         <= SEND;
                    end else begin
                        m_axis.tvalid <= 1'b0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        m_axis.tvalid <= 1'b0;
                        busy          <= 1'b0;
                        cnt           <= '0;
                        state         <= ARB;
                    end else if (to_hit) begin
                        m_axis.tvalid <= 1'b0;
                        busy          <= 1'b0;
                        cnt           <= '0;
                        timeout_err   <= 1'b1;
                        err_id        <= gnt_id;
                        state         <= ARB;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    m_axis.tvalid <= 1'b0;
                    busy          <= 1'b0;
                    cnt           <= '0;
                    state         <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed bench for axis_i2c_arbiter (4 ports, 16-bit words, TIMEOUT=8).
module tb_axis_i2c_arbiter;
    import i2c_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       s_tvalid;
    logic [N*W-1:0]     s_tdata;
    logic [N-1:0]       s_tready;
    logic [N-1:0]       req_en;
    logic [GNT_W-1:0]   gnt_id;
    logic               busy;
    logic               timeout_err;
    logic [GNT_W-1:0]   err_id;

    int total = 0;
    int bad   = 0;

    axis_if #(.DW(W)) mif ();

    axis_i2c_arbiter #(
        .NUM_REQ         (N),
        .I2C_DATA_WIDTH  (8),
        .AXIS_DATA_WIDTH (W),
        .TIMEOUT         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tready    (s_tready),
        .req_en      (req_en),
        .m_axis      (mif),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_word(input int port, input axis_word_t w);
        s_tdata[port*W +: W] = w;
    endtask

    axis_word_t rx[$];
    axis_word_t w_exp;
    int         order[5] = '{0, 1, 2, 3, 0};
    int         wait_cnt;

    initial begin
        rst        = 1'b1;
        s_tvalid   = '0;
        s_tdata    = '0;
        req_en     = '0;
        mif.tready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_tvalid", 32'(mif.tvalid), 32'd0);
        chk("rst_tdata",  32'(mif.tdata),  32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_toerr",  32'(timeout_err), 32'd0);
        chk("rst_errid",  32'(err_id),     32'd0);
        chk("rst_gnt",    32'(gnt_id),     32'd3);
        chk("rst_sready", 32'(s_tready),   32'd0);

        // Single request on port 2
        rst      = 1'b0;
        req_en   = 4'hF;
        s_tvalid = 4'b0100;
        set_word(2, 16'hA55A);
        step();
        chk("single_tvalid", 32'(mif.tvalid), 32'd1);
        chk("single_tdata",  32'(mif.tdata),  32'hA55A);
        chk("single_gnt",    32'(gnt_id),     32'd2);
        chk("single_busy",   32'(busy),       32'd1);
        chk("single_sready_lo", 32'(s_tready), 32'd0);
        mif.tready = 1'b1;
        #1;
        chk("single_sready_hs", 32'(s_tready), 32'b0100);
        step();
        s_tvalid   = '0;
        mif.tready = 1'b0;
        chk("single_tvalid_done", 32'(mif.tvalid), 32'd0);
        chk("single_busy_done",   32'(busy),       32'd0);
        chk("single_gnt_hold",    32'(gnt_id),     32'd2);

        // All four ports continuously valid, fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, axis_word_t'(16'h1111 * (i + 1)));
        s_tvalid   = 4'hF;
        mif.tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            w_exp = axis_word_t'(16'h1111 * (order[k] + 1));
            chk("rr_tvalid", 32'(mif.tvalid), 32'd1);
            chk("rr_gnt",    32'(gnt_id),     32'(order[k]));
            chk("rr_tdata",  32'(mif.tdata),  32'(w_exp));
            chk("rr_sready", 32'(s_tready),   32'(1 << order[k]));
            step();
            chk("rr_bubble", 32'(mif.tvalid), 32'd0);
        end
        s_tvalid   = '0;
        mif.tready = 1'b0;

        // Mask: ports 1 and 3 valid, port 3 disabled
        set_word(1, 16'hB001);
        set_word(3, 16'hB003);
        s_tvalid   = 4'b1010;
        req_en     = 4'b0111;
        mif.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mask_gnt",    32'(gnt_id),     32'd1);
            chk("mask_tvalid", 32'(mif.tvalid), 32'd1);
            step();
            chk("mask_bubble", 32'(mif.tvalid), 32'd0);
        end
        step();
        chk("mask_mid_gnt", 32'(gnt_id), 32'd1);
        mif.tready = 1'b0;
        req_en     = 4'hF;
        step();
        chk("mask_hold_gnt",   32'(gnt_id),    32'd1);
        chk("mask_hold_tdata", 32'(mif.tdata), 32'hB001);
        mif.tready = 1'b1;
        #1;
        chk("mask_sready", 32'(s_tready), 32'b0010);
        step();
        chk("mask_done_tvalid", 32'(mif.tvalid), 32'd0);
        step();
        chk("mask_next_gnt",   32'(gnt_id),    32'd3);
        chk("mask_next_tdata", 32'(mif.tdata), 32'hB003);
        step();
        s_tvalid   = '0;
        mif.tready = 1'b0;

        // Timeout on port 2 with transmitter stalled
        set_word(2, 16'hBEEF);
        s_tvalid = 4'b0100;
        step();
        s_tvalid = '0;
        chk("to_busy",  32'(busy),      32'd1);
        chk("to_gnt",   32'(gnt_id),    32'd2);
        chk("to_tdata", 32'(mif.tdata), 32'hBEEF);
        for (int k = 1; k < 7; k++) begin
            step();
            chk("to_wait_sready", 32'(s_tready),    32'd0);
            chk("to_wait_err",    32'(timeout_err), 32'd0);
        end
        step();
        chk("to_force_sready", 32'(s_tready),   32'b0100);
        chk("to_force_tvalid", 32'(mif.tvalid), 32'd1);
        step();
        chk("to_err_pulse",  32'(timeout_err), 32'd1);
        chk("to_err_id",     32'(err_id),      32'd2);
        chk("to_err_tvalid", 32'(mif.tvalid),  32'd0);
        chk("to_err_busy",   32'(busy),        32'd0);
        step();
        chk("to_err_clear",  32'(timeout_err), 32'd0);
        chk("to_errid_hold", 32'(err_id),      32'd2);

        // Reset on the third SEND cycle
        set_word(3, 16'h3333);
        s_tvalid = 4'b1000;
        step();
        chk("rs_gnt", 32'(gnt_id), 32'd3);
        step();
        step();
        rst      = 1'b1;
        s_tvalid = 4'hF;
        step();
        chk("rs_tvalid", 32'(mif.tvalid), 32'd0);
        chk("rs_tdata",  32'(mif.tdata),  32'd0);
        chk("rs_busy",   32'(busy),       32'd0);
        chk("rs_gnt_rst", 32'(gnt_id),    32'd3);
        chk("rs_errid",  32'(err_id),     32'd0);
        rst = 1'b0;
        step();
        chk("rs_next_gnt",    32'(gnt_id),     32'd0);
        chk("rs_next_tvalid", 32'(mif.tvalid), 32'd1);
        s_tvalid   = '0;
        mif.tready = 1'b1;
        step();
        mif.tready = 1'b0;

        // Two queued words through a slow transmitter model
        set_word(1, 16'h1234);
        set_word(2, 16'h5678);
        s_tvalid = 4'b0110;
        wait_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mif.tready) begin
                mif.tready = 1'b0;
            end else if (mif.tvalid) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mif.tready = 1'b1;
                    #1;
                    rx.push_back(mif.tdata);
                    s_tvalid = s_tvalid & ~s_tready;
                    wait_cnt = 0;
                end
            end
        end
        chk("e2e_count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("e2e_word0", 32'(rx[0]), 32'h1234);
            chk("e2e_word1", 32'(rx[1]), 32'h5678);
        end
        chk("e2e_idle", 32'(mif.tvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_i2c_arbiter.md
Name: axis_i2c_arbiter

Overview:
Round-robin arbiter sharing the single AXIS-fed I2C transmitter between NUM_REQ independent requesters. It registers the winning requester's word and presents it on one AXIS master port, which connects to the transmitter's axis_if slave port. It holds the grant until the transmitter accepts the word, or until a timeout discards it. Per-port enable masks and error reporting allow system firmware to fence off misbehaving requesters.

Parameters:
NUM_REQ, 4, number of requester ports (2..16)
I2C_DATA_WIDTH, 8, I2C byte width
AXIS_DATA_WIDTH, I2C_DATA_WIDTH*2, word width per requester and on the master port
TIMEOUT, 256, cycles in SEND without handshake before the word is discarded; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_tvalid  in  NUM_REQ  per-requester valid
s_tdata  in  NUM_REQ*AXIS_DATA_WIDTH  per-requester data; port i occupies bits [i*W +: W]
s_tready  out  NUM_REQ  per-requester ready
req_en  in  NUM_REQ  per-port enable; disabled ports are never granted
m_axis  axis_if.master  -  tvalid/tdata/tready toward the I2C transmitter
gnt_id  out  $clog2(NUM_REQ)  index of current or last grant
busy  out  1  high while in SEND
timeout_err  out  1  one-cycle pulse when a word is discarded
err_id  out  $clog2(NUM_REQ)  port of the last discarded word; holds until the next error

Behaviour:
- Reset (rst=1 on a clk edge):
  - state=ARB; m_axis.tvalid=0; m_axis.tdata=0; s_tready=0; busy=0; timeout_err=0; err_id=0; timeout counter=0.
  - last_gnt=NUM_REQ-1, so port 0 has first priority; gnt_id=NUM_REQ-1.
- States are ARB and SEND.
- ARB:
  - eligible = s_tvalid & req_en.
  - If eligible is nonzero, pick the first set bit searching upward from last_gnt+1, with wrap-around.
  - Register: gnt_id=winner, last_gnt=winner, m_axis.tdata=s_tdata[winner], m_axis.tvalid=1, counter=0, go to SEND.
  - Otherwise stay in ARB with m_axis.tvalid=0.
- SEND:
  - m_axis.tvalid and tdata are held stable; the transmitter samples tdata before raising tready.
  - s_tready[i] = (state==SEND) && (i==gnt_id) && m_axis.tready. This is combinational, so upstream and downstream handshakes occur in the same cycle.
  - On handshake: m_axis.tvalid=0, go to ARB.
  - If TIMEOUT!=0, counter==TIMEOUT-1 and there is no handshake:
    - Force s_tready[gnt_id]=1 for this cycle; the word is consumed and dropped.
    - m_axis.tvalid=0; pulse timeout_err; err_id=gnt_id; go to ARB.
- Latency and throughput:
  - An s_tvalid sampled in ARB gives m_axis.tvalid on the next cycle.
  - After a handshake there is one idle ARB cycle before the next m_axis.tvalid.
- Boundary conditions:
  - A req_en change or s_tvalid drop by a non-granted port during SEND has no effect on the current grant.
  - If the granted requester violates AXIS by dropping s_tvalid, the registered word is still delivered.
  - If several ports request simultaneously, the round-robin order guarantees each eligible port a grant within NUM_REQ grants.
  - When only one port requests, it is re-granted after each handshake.
  - rst in SEND abandons the word. The transmitter may already have captured it; this is accepted.
  - A handshake and a timeout in the same cycle count as a handshake, with no error.
- Counter width is $clog2(TIMEOUT+1) and it never wraps, because it is cleared on leaving SEND.

Decomposition:
- Package i2c_arb_pkg:
  - state enum (ARB, SEND), logic [1:0].
  - localparam GNT_W=$clog2(NUM_REQ) helper.
  - typedef for the AXIS_DATA_WIDTH word.
- Sub-module rr_arbiter (combinational):
  - Inputs: req vector, last_gnt.
  - Outputs: winner index, any_req.
  - Implemented as a double-width rotate-and-priority-encode.
  - Reused by future I2C command schedulers.

Test Plan:
- Single request: port 2 s_tdata=16'hA55A, transmitter idle -> m_axis.tvalid next cycle, tdata=16'hA55A, gnt_id=2; s_tready[2] coincides with m_axis.tready; busy falls one cycle later.
- All four ports valid continuously, req_en=4'hF, after reset -> grant order 0,1,2,3,0; each word delivered unchanged; one ARB bubble between words.
- Mask: ports 1 and 3 valid, req_en=4'b0111 -> only port 1 granted repeatedly; set req_en[3] mid-SEND -> port 3 granted next, not the current word.
- Timeout: TIMEOUT=8, m_axis.tready held 0 -> after 8 SEND cycles s_tready[gnt_id]=1 and timeout_err pulses 1 cycle, err_id=gnt_id, m_axis.tvalid=0.
- Reset mid-SEND: assert rst on the 3rd SEND cycle -> next cycle all outputs at reset values; port 0 wins the next arbitration.
- End-to-end with transmitter: two ports queue 16'h1234 and 16'h5678 -> both appear serially on sda in round-robin order; no word is lost or duplicated.
